pixsel_mode_ctl: RTL and testbench

PIXSEL_MODE_CTL -- requirements
Module: pixsel_mode_ctl

---
 rtl/pixsel_mode_pkg.sv | 13 +
 rtl/sw_debounce.sv | 36 +++
 rtl/pixsel_mode_ctl.sv | 68 ++++++
 tb/tb_pixsel_mode_ctl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pixsel_mode_pkg.sv
// pixsel_mode_pkg: FSM state encodings and default parameters for the pixsel mode controller
package pixsel_mode_pkg;
  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    RUN      = 2'd1,
    PEND     = 2'd2,
    BLANK    = 2'd3
  } state_t;
  localparam int         DEF_DEB_CYCLES   = 1000000;
  localparam int         DEF_BLANK_FRAMES = 2;
  localparam bit         DEF_VS_POL       = 1'b1;
  localparam logic [7:0] DEF_INIT_MODE    = 8'h00;
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchronizer plus down-counter debounce for the 8 board switches
module sw_debounce
  import pixsel_mode_pkg::*;
#(
  parameter int         DEB_CYCLES = DEF_DEB_CYCLES,
  parameter logic [7:0] INIT       = DEF_INIT_MODE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  output logic [7:0] stable
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [7:0] s1, s2, cand;
  logic [CW-1:0] cnt;
  // stable is copied on the edge that takes the counter to 0, giving DEB_CYCLES+3 total latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= INIT;
      s2     <= INIT;
      cand   <= INIT;
      stable <= INIT;
      cnt    <= CW'(DEB_CYCLES);
    end else begin
      s1 <= sw;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= CW'(DEB_CYCLES);
      end else begin
        if (cnt != '0) cnt <= cnt - CW'(1);
        if (cnt <= CW'(1)) stable <= cand;
      end
    end
  end
endmodule

// File: rtl/pixsel_mode_ctl.sv
// pixsel_mode_ctl: frame-aligned mode switching with post-change blanking for pixsel
module pixsel_mode_ctl
  import pixsel_mode_pkg::*;
#(
  parameter int         DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int         BLANK_FRAMES = DEF_BLANK_FRAMES,
  parameter bit         VS_POL       = DEF_VS_POL,
  parameter logic [7:0] INIT_MODE    = DEF_INIT_MODE
) (
  input  logic       CLK_I,
  input  logic       RSTN_I,
  input  logic [7:0] SW_I,
  input  logic       VS_I,
  input  logic       FB_RDY_I,
  output logic [7:0] MODE_O,
  output logic       BLANK_O,
  output logic       CHG_O,
  output logic [1:0] STATE_O
);
  state_t state, nxt;
  logic [7:0] stable;
  logic [3:0] fcnt;
  logic vs_q, vs_start, load, blank_d, diff;
  sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .INIT(INIT_MODE)) u_deb (
    .clk   (CLK_I),
    .rst_n (RSTN_I),
    .sw    (SW_I),
    .stable(stable)
  );
  assign vs_start = (VS_I == VS_POL) && (vs_q != VS_POL);
  assign diff     = stable != MODE_O;
  assign STATE_O  = state;
  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      state   <= WAIT_RDY;
      MODE_O  <= INIT_MODE;
      BLANK_O <= 1'b1;
      CHG_O   <= 1'b0;
      fcnt    <= 4'd0;
      vs_q    <= ~VS_POL;
    end else begin
      state   <= nxt;
      vs_q    <= VS_I;
      BLANK_O <= blank_d;
      CHG_O   <= load;
      if (load) begin
        MODE_O <= stable;
        fcnt   <= 4'(BLANK_FRAMES);
      end else if (state == BLANK && vs_start && fcnt != 4'd0) begin
        fcnt <= fcnt - 4'd1;
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      WAIT_RDY: nxt = vs_start ? RUN : WAIT_RDY;
      RUN:      nxt = diff ? PEND : RUN;
      PEND:     nxt = !diff ? RUN : vs_start ? BLANK : PEND;
      BLANK:    nxt = (vs_start && fcnt <= 4'd1) ? (diff ? PEND : RUN) : BLANK;
    endcase
    if (!FB_RDY_I) nxt = WAIT_RDY;
  end
  always_comb begin
    load    = (state == PEND) && (nxt == BLANK);
    blank_d = (nxt == WAIT_RDY) || (nxt == BLANK);
  end
endmodule

// File: tb/tb_pixsel_mode_ctl.sv
// tb_pixsel_mode_ctl: directed scenarios with a CHG_O-driven scoreboard of expected mode words
module tb_pixsel_mode_ctl;
  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] sw;
  logic       vs;
  logic       fb;
  logic [7:0] mode;
  logic       blank, chg;
  logic [1:0] st;
  int total = 0;
  int passed = 0;
  logic [7:0] exp_q[$];

  pixsel_mode_ctl #(.DEB_CYCLES(16), .BLANK_FRAMES(2)) dut (
    .CLK_I   (clk),
    .RSTN_I  (rstn),
    .SW_I    (sw),
    .VS_I    (vs),
    .FB_RDY_I(fb),
    .MODE_O  (mode),
    .BLANK_O (blank),
    .CHG_O   (chg),
    .STATE_O (st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    tick(1);
    vs = 1'b0;
    tick(1);
  endtask

  always @(negedge clk) begin
    if (chg) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL chg_unexpected: got pulse with mode %h expected no pulse at %0t", mode, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (mode === e) passed++;
        else $display("FAIL chg_mode: got %h expected %h at %0t", mode, e, $time);
      end
    end
  end

  initial begin
    rstn = 1'b0; sw = 8'h00; vs = 1'b0; fb = 1'b1;
    tick(3);
    chk("rst_mode", mode, 8'h00);
    chk("rst_blank", {7'd0, blank}, 8'd1);
    chk("rst_chg", {7'd0, chg}, 8'd0);
    chk("rst_state", {6'd0, st}, 8'd0);
    rstn = 1'b1;
    tick(2);
    chk("wait_state", {6'd0, st}, 8'd0);
    vs_pulse();
    chk("run_state", {6'd0, st}, 8'd1);
    chk("run_blank", {7'd0, blank}, 8'd0);
    chk("run_mode", mode, 8'h00);
    for (int i = 0; i < 20; i++) begin
      sw = (i % 2 == 0) ? 8'h05 : 8'h00;
      tick(10);
      chk("bounce_state", {6'd0, st}, 8'd1);
    end
    sw = 8'h00;
    tick(30);
    chk("bounce_end_state", {6'd0, st}, 8'd1);
    chk("bounce_end_mode", mode, 8'h00);
    sw = 8'h05;
    tick(18);
    chk("deb_not_yet", {6'd0, st}, 8'd1);
    tick(2);
    chk("pend_state", {6'd0, st}, 8'd2);
    chk("pend_mode", mode, 8'h00);
    chk("pend_blank", {7'd0, blank}, 8'd0);
    exp_q.push_back(8'h05);
    vs_pulse();
    chk("chg1_mode", mode, 8'h05);
    chk("chg1_state", {6'd0, st}, 8'd3);
    chk("chg1_blank", {7'd0, blank}, 8'd1);
    sw = 8'h0A;
    tick(22);
    chk("blank_hold_mode", mode, 8'h05);
    chk("blank_hold_state", {6'd0, st}, 8'd3);
    vs_pulse();
    chk("blank_f1", {7'd0, blank}, 8'd1);
    vs_pulse();
    chk("blank_f2_state", {6'd0, st}, 8'd2);
    chk("blank_f2_blank", {7'd0, blank}, 8'd0);
    chk("blank_f2_mode", mode, 8'h05);
    exp_q.push_back(8'h0A);
    vs_pulse();
    chk("chg2_mode", mode, 8'h0A);
    chk("chg2_blank", {7'd0, blank}, 8'd1);
    vs_pulse();
    chk("chg2_f1", {7'd0, blank}, 8'd1);
    vs_pulse();
    chk("chg2_run", {6'd0, st}, 8'd1);
    chk("chg2_unblank", {7'd0, blank}, 8'd0);
    sw = 8'h05;
    tick(22);
    chk("fb_pend", {6'd0, st}, 8'd2);
    fb = 1'b0;
    tick(1);
    chk("fb_state", {6'd0, st}, 8'd0);
    chk("fb_blank", {7'd0, blank}, 8'd1);
    chk("fb_mode", mode, 8'h0A);
    fb = 1'b1;
    tick(3);
    vs_pulse();
    chk("fb_recover", {6'd0, st}, 8'd2);
    exp_q.push_back(8'h05);
    vs_pulse();
    chk("chg3_mode", mode, 8'h05);
    chk("chg3_state", {6'd0, st}, 8'd3);
    rstn = 1'b0;
    tick(1);
    chk("rst_blank_mode", mode, 8'h00);
    chk("rst_blank_state", {6'd0, st}, 8'd0);
    chk("rst_blank_chg", {7'd0, chg}, 8'd0);
    rstn = 1'b1;
    tick(5);
    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
